// File: rtl/mux24_arbiter.sv
// mux24_arbiter: round-robin arbiter driving a registered 2:1 mux path with a bounded hold time
module mux24_arbiter #(
  parameter int WIDTH    = 4,
  parameter int MAX_HOLD = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_a_i,
  input  logic             req_b_i,
  input  logic [0:WIDTH-1] a_i,
  input  logic [0:WIDTH-1] b_i,
  output logic             gnt_a_o,
  output logic             gnt_b_o,
  output logic             select_o,
  output logic [0:WIDTH-1] y_o,
  output logic             y_valid_o
);
  localparam int HW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
  localparam logic [HW-1:0] HOLD_MAX = HW'(MAX_HOLD - 1);
  typedef enum logic [1:0] {IDLE, GRANT_A, GRANT_B} state_t;
  state_t           state_q, state_d;
  logic             last_q, last_d;
  logic [HW-1:0]    hold_q, hold_d;
  logic [0:WIDTH-1] y_q, y_d;
  logic             y_valid_q, y_valid_d;
  logic [HW-1:0]    hold_inc;
  assign hold_inc  = (hold_q == HOLD_MAX) ? hold_q : hold_q + HW'(1);
  assign gnt_a_o   = (state_q == GRANT_A);
  assign gnt_b_o   = (state_q == GRANT_B);
  assign select_o  = gnt_b_o;
  assign y_o       = y_q;
  assign y_valid_o = y_valid_q;
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    last_d  = last_q;
    case (state_q)
      IDLE:
        state_d = (req_a_i && req_b_i) ? (last_q ? GRANT_A : GRANT_B) :
                  req_a_i ? GRANT_A : req_b_i ? GRANT_B : IDLE;
      GRANT_A:
        if (!req_a_i) state_d = req_b_i ? GRANT_B : IDLE;
        else if (req_b_i && hold_q == HOLD_MAX) state_d = GRANT_B;
        else hold_d = hold_inc;
      GRANT_B:
        if (!req_b_i) state_d = req_a_i ? GRANT_A : IDLE;
        else if (req_a_i && hold_q == HOLD_MAX) state_d = GRANT_A;
        else hold_d = hold_inc;
      default: state_d = IDLE;
    endcase
    // a fresh owner starts its hold window from zero
    if (state_d != state_q && state_d != IDLE) begin
      hold_d = '0;
      last_d = (state_d == GRANT_B);
    end
  end
  always_comb begin
    y_d       = y_q;
    y_valid_d = 1'b0;
    if (gnt_a_o && req_a_i) begin
      y_d       = a_i;
      y_valid_d = 1'b1;
    end else if (gnt_b_o && req_b_i) begin
      y_d       = b_i;
      y_valid_d = 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      hold_q    <= '0;
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      hold_q    <= hold_d;
      y_q       <= y_d;
      y_valid_q <= y_valid_d;
    end
  end
endmodule

// File: doc/mux24_arbiter.md
Name: mux24_arbiter

Overview:
- Round-robin arbiter and sequencer for a shared WIDTH-bit 2:1 mux path, in the same style as the ex4 mux24 datapath.
- Two requesters (A, B) each present data and a request. The block grants one requester at a time and drives the mux select.
- It registers the selected data onto a single output bus with a valid strobe.
- A hold counter bounds how long one requester may keep the path while the other waits.

Parameters:
- WIDTH, 4, data width of a, b and y.
- MAX_HOLD, 4, max consecutive granted cycles for one requester while the other is requesting (must be >= 1).

Ports:
- clk  input  1  system clock, rising-edge active.
- rst_n  input  1  reset; one clock, reset asynchronous and active-low.
- req_a  input  1  requester A wants the path.
- req_b  input  1  requester B wants the path.
- a  input  [0:WIDTH-1]  requester A data.
- b  input  [0:WIDTH-1]  requester B data.
- gnt_a  output  1  A owns the path (registered).
- gnt_b  output  1  B owns the path (registered).
- select  output  1  mux select: 0 = a, 1 = b (registered).
- y  output  [0:WIDTH-1]  registered selected data.
- y_valid  output  1  y updated this cycle with a granted requester's data.

Behaviour:
- States: IDLE, GRANT_A, GRANT_B. Internal registers: last (last granted, 0 = A, 1 = B) and hold_cnt (width sized for MAX_HOLD-1).
- Reset (rst_n=0, asynchronous, any time including mid-grant):
  - state=IDLE, gnt_a=0, gnt_b=0, select=0, y=0, y_valid=0, hold_cnt=0.
  - last=B, so A wins the first tie.
- gnt_a=1 only in GRANT_A. gnt_b=1 only in GRANT_B. select=1 only in GRANT_B. gnt_a and gnt_b are never both 1.
- IDLE transitions:
  - req_a & req_b: grant the requester that is not last.
  - Only one requesting: grant it.
  - Neither requesting: stay in IDLE.
- GRANT_X (other requester is Y), evaluated each edge:
  - If req_x=0: go to GRANT_Y if req_y=1, else IDLE.
  - Else if req_y=1 and hold_cnt == MAX_HOLD-1: preempt to GRANT_Y.
  - Else stay in GRANT_X; hold_cnt increments, saturating at MAX_HOLD-1.
  - hold_cnt increments whether or not Y is requesting, so a long solo owner is preempted on the first edge after Y requests.
- Entering any GRANT state: hold_cnt cleared to 0, last updated to the new owner.
- A->B and B->A handoffs are direct, with no IDLE bubble.
- Data path, on each edge:
  - If (gnt_a & req_a): y <= a, y_valid <= 1.
  - Else if (gnt_b & req_b): y <= b, y_valid <= 1.
  - Otherwise y holds its value and y_valid <= 0.
- Latency: request sampled at edge N gives grant visible after edge N. First y_valid follows edge N+1 with the data sampled at that edge.
- Data sampled on the same edge as a state change uses the old grant. On preemption, the outgoing owner's last beat is accepted on that edge.
- Request drops while granted: no y_valid for that cycle; the grant is released on the same edge.

Test Plan:
1. Reset: drive all inputs to 1 and assert rst_n=0 mid-cycle -> immediately gnt_a=gnt_b=select=y_valid=0 and y=4'b0000, with no clock edge needed.
2. Solo A: from reset, req_a=1, a=4'b0101 for 3 edges, then req_a=0.
   - After edge 1: gnt_a=1, select=0.
   - After edges 2-3: y=0101, y_valid=1.
   - After the edge with req_a=0: gnt_a=0, y_valid=0, y holds 0101.
3. Tie and fairness (MAX_HOLD=4): req_a=req_b=1 from reset, a=4'h3, b=4'hC.
   - Edge 1: GRANT_A.
   - Edges 2-5: y=3 valid.
   - After edge 5: gnt_b=1, select=1.
   - Edges 6-9: y=C valid.
   - Grant then returns to A.
4. Handoff without bubble: A granted, req_b=1, drop req_a -> gnt_b=1 on the next edge, and y=b valid on the following edge; gnt_a and gnt_b never overlap.
5. Late contender: A granted alone for 10 cycles (hold_cnt saturated), then raise req_b -> switch to GRANT_B on the first edge with req_b=1.
6. Reset mid-grant: while in GRANT_B with y_valid=1, pulse rst_n low -> all outputs 0. After release with req_a=req_b=1, A is granted first.
